i2c_temp_responder: RTL and testbench
=====================================

Name: i2c_temp_responder

Overview:
I2C target (responder) modelling the ADT7420 register interface, the other end of our I2C write-pointer/read-data initiator. It oversamples SCL/SDA on the system clock, decodes START/STOP, address, pointer and data bytes, ACKs, and returns temperature MSB/LSB plus config/ID registers. It serves as a loopback target for bench and on-board self-test of the initiator without the physical sensor.

Parameters:
DEV_ADDR, 7'h48, 7-bit target address (ADT7420 with A1=A0=0)
ID_VALUE, 8'hCB, value returned at pointer 0x0B
SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (minimum 2)

Ports:
clk  input  1  system clock; must be at least 8x the SCL rate
reset  input  1  synchronous, active-high
scl_in  input  1  SCL line level
sda_in  input  1  SDA line level
sda_oe  output  1  1 = pull SDA low (open drain); 0 = release
temp_data  input  16  live temperature word {MSB,LSB}
reg_ptr  output  8  current register pointer
wr_data  output  8  last data byte written by initiator
wr_strobe  output  1  one-clk pulse when a data byte is received and ACKed
busy  output  1  1 from address match until STOP/NACK/mismatch
cfg_reg  output  8  config register (pointer 0x03)

Behaviour:
- Reset: sda_oe=0, reg_ptr=0x00, wr_data=0x00, wr_strobe=0, busy=0, cfg_reg=0x00, state IDLE. Reset mid-transfer releases SDA on the next clk; the remainder of the transaction is ignored until a new START.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop; event latency is SYNC_STAGES+1 clks.
- START = sda falling while scl high; STOP = sda rising while scl high. Both are valid in every state.
  - START (including repeated START) -> ADDR with bit count cleared.
  - STOP -> IDLE with sda_oe=0.
- Bits are sampled on the synchronized SCL rising edge, MSB first. sda_oe changes only on the synchronized SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr[7:1] != DEV_ADDR -> IGNORE (never drives SDA). On match -> ADDR_ACK, busy=1.
  - ADDR_ACK: sda_oe=1 from the falling edge after bit 8 until the next falling edge. Then, by R/W bit:
    - W: -> PTR.
    - R: snapshot temp_data into the read holding register at the match, load the tx shifter with the byte at reg_ptr, -> RDATA.
  - PTR: 8 bits -> reg_ptr, ACK -> WDATA.
  - WDATA: 8 bits.
    - ACK; wr_data updated; wr_strobe pulses on the ACK falling edge.
    - If reg_ptr==0x03, cfg_reg<=byte. Writes to other pointers are ACKed and otherwise discarded.
    - reg_ptr+=1; stay in WDATA.
  - RDATA: drive sda_oe = ~bit on each falling edge for 8 bits -> RACK.
  - RACK: release SDA; sample initiator bit on the rising edge.
    - ACK(0): reg_ptr+=1, load the next byte -> RDATA.
    - NACK(1): -> IGNORE, busy=0.
  - IGNORE: sda_oe=0; wait for START/STOP.
- Read map: 0x00 = snapshot[15:8]; 0x01 = snapshot[7:0]; 0x03 = cfg_reg; 0x0B = ID_VALUE; all others = 0xFF. The snapshot is held for the whole read so the MSB/LSB pair is coherent.
- reg_ptr is 8-bit and wraps 0xFF -> 0x00.
- A START or STOP inside a byte aborts it; no wr_strobe and no pointer change.

Test Plan:
- temp_data=16'h0C80; write addr 0x90, ptr 0x00, repeated START, addr 0x91, read 2 bytes (ACK, NACK) -> bytes 0x0C,0x80; ACK driven on all 3 ACK slots; reg_ptr=0x02 afterwards; busy=0 after NACK.
- Addr 0x92 (7'h49) write -> sda_oe stays 0 through the 9th clock (NACK); no wr_strobe; reg_ptr unchanged.
- Write ptr 0x03, data 0x80, STOP; then ptr 0x03 + read -> cfg_reg=0x80, one wr_strobe with wr_data=0x80, read returns 0x80.
- Ptr 0x0B read 1 byte -> 0xCB; ptr 0xFF read 2 bytes -> 0xFF then snapshot MSB; reg_ptr wraps to 0x00 then 0x01.
- temp_data changes from 0x0C80 to 0x1234 between the MSB and LSB bytes of one read -> returns 0x0C,0x80.
- Reset asserted mid-RDATA while sda_oe=1 -> sda_oe=0 next clk, state IDLE; a subsequent full transaction completes normally.

Source files
------------

// File: rtl/i2c_temp_responder_if.sv
// i2c_temp_responder_if: I2C line and register-side signals of the ADT7420-style target
interface i2c_temp_responder_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [15:0] temp_data;
    logic [7:0]  reg_ptr;
    logic [7:0]  wr_data;
    logic        wr_strobe;
    logic        busy;
    logic [7:0]  cfg_reg;
    modport master (
        output scl_in, sda_in, temp_data,
        input  sda_oe, reg_ptr, wr_data, wr_strobe, busy, cfg_reg
    );
    modport slave (
        input  scl_in, sda_in, temp_data,
        output sda_oe, reg_ptr, wr_data, wr_strobe, busy, cfg_reg
    );
endinterface

// File: rtl/i2c_temp_responder.sv
// i2c_temp_responder: oversampled I2C target emulating the ADT7420 pointer/register interface
module i2c_temp_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter logic [7:0] ID_VALUE    = 8'hCB,
    parameter int         SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 reset,
    i2c_temp_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ACK, PTR, WDATA, RDATA, RACK, IGNORE} state_t;
    state_t                 state, state_n, ack_to, ack_to_n;
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic                   scl_s, sda_s, scl_p, sda_p;
    logic                   rise, fall, start, stop;
    logic [3:0]             cnt, cnt_n;
    logic [7:0]             sh, sh_n, tx, tx_n, rx_byte, rd_byte;
    logic [7:0]             ptr_n, wr_data_n, cfg_n;
    logic [15:0]            snap, snap_n;
    logic                   commit, commit_n, oe_n, strobe_n, busy_n;
    assign scl_s   = scl_q[SYNC_STAGES-1];
    assign sda_s   = sda_q[SYNC_STAGES-1];
    assign rise    = scl_s & ~scl_p;
    assign fall    = ~scl_s & scl_p;
    assign start   = scl_s & scl_p & sda_p & ~sda_s;
    assign stop    = scl_s & scl_p & ~sda_p & sda_s;
    assign rx_byte = {sh[6:0], sda_s};
    // line synchronizers followed by one edge-detect stage; left unreset so reset cannot fake bus events
    always_ff @(posedge clk) begin
        scl_q <= {scl_q[SYNC_STAGES-2:0], bus.scl_in};
        sda_q <= {sda_q[SYNC_STAGES-2:0], bus.sda_in};
        scl_p <= scl_s;
        sda_p <= sda_s;
    end
    // read map; temperature comes from the snapshot so MSB/LSB stay coherent within one read
    always_comb begin
        rd_byte = bus.reg_ptr == 8'h00 ? snap[15:8] :
                  bus.reg_ptr == 8'h01 ? snap[7:0] :
                  bus.reg_ptr == 8'h03 ? bus.cfg_reg :
                  bus.reg_ptr == 8'h0B ? ID_VALUE : 8'hFF;
    end
    // protocol state machine: START/STOP override everything, bits on SCL rise, SDA drive on SCL fall
    always_comb begin
        state_n   = state;
        ack_to_n  = ack_to;
        cnt_n     = cnt;
        sh_n      = sh;
        tx_n      = tx;
        snap_n    = snap;
        commit_n  = commit;
        oe_n      = bus.sda_oe;
        ptr_n     = bus.reg_ptr;
        wr_data_n = bus.wr_data;
        cfg_n     = bus.cfg_reg;
        strobe_n  = 1'b0;
        busy_n    = bus.busy;
        if (start) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: if (rise) begin
                    sh_n  = rx_byte;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n    = 4'd0;
                        state_n  = ACK;
                        commit_n = state == WDATA;
                        ack_to_n = state == ADDR ? (rx_byte[0] ? RDATA : PTR) : WDATA;
                        if (state == PTR) ptr_n = rx_byte;
                        if (state == ADDR) begin
                            busy_n  = rx_byte[7:1] == DEV_ADDR;
                            state_n = busy_n ? ACK : IGNORE;
                            snap_n  = rx_byte[0] ? bus.temp_data : snap;
                        end
                    end
                end
                ACK: if (fall) begin
                    if (cnt == 4'd0) begin
                        cnt_n = 4'd1;
                        oe_n  = 1'b1;
                        if (commit) begin
                            strobe_n  = 1'b1;
                            wr_data_n = sh;
                            cfg_n     = bus.reg_ptr == 8'h03 ? sh : bus.cfg_reg;
                            ptr_n     = bus.reg_ptr + 8'd1;
                        end
                    end else begin
                        cnt_n   = 4'd0;
                        oe_n    = 1'b0;
                        state_n = ack_to;
                        if (ack_to == RDATA) begin
                            cnt_n = 4'd1;
                            oe_n  = ~rd_byte[7];
                            tx_n  = {rd_byte[6:0], 1'b0};
                        end
                    end
                end
                RDATA: if (fall) begin
                    cnt_n = cnt + 4'd1;
                    oe_n  = ~tx[7];
                    tx_n  = {tx[6:0], 1'b0};
                    if (cnt == 4'd8) begin
                        cnt_n   = 4'd0;
                        oe_n    = 1'b0;
                        state_n = RACK;
                    end
                end
                RACK: if (rise && cnt == 4'd0) begin
                    ptr_n = bus.reg_ptr + 8'd1;
                    cnt_n = 4'd1;
                    if (sda_s) begin
                        state_n = IGNORE;
                        busy_n  = 1'b0;
                    end
                end else if (fall && cnt == 4'd1) begin
                    state_n = RDATA;
                    oe_n    = ~rd_byte[7];
                    tx_n    = {rd_byte[6:0], 1'b0};
                end
                default: ;
            endcase
        end
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ack_to        <= IDLE;
            cnt           <= '0;
            sh            <= '0;
            tx            <= '0;
            snap          <= '0;
            commit        <= 1'b0;
            bus.sda_oe    <= 1'b0;
            bus.reg_ptr   <= '0;
            bus.wr_data   <= '0;
            bus.wr_strobe <= 1'b0;
            bus.busy      <= 1'b0;
            bus.cfg_reg   <= '0;
        end else begin
            state         <= state_n;
            ack_to        <= ack_to_n;
            cnt           <= cnt_n;
            sh            <= sh_n;
            tx            <= tx_n;
            snap          <= snap_n;
            commit        <= commit_n;
            bus.sda_oe    <= oe_n;
            bus.reg_ptr   <= ptr_n;
            bus.wr_data   <= wr_data_n;
            bus.wr_strobe <= strobe_n;
            bus.busy      <= busy_n;
            bus.cfg_reg   <= cfg_n;
        end
    end
endmodule

// File: tb/tb_i2c_temp_responder.sv
// tb_i2c_temp_responder: I2C initiator model with bus-snooping scoreboard for i2c_temp_responder
module tb_i2c_temp_responder;
    localparam int Q = 4;
    typedef struct packed {logic [7:0] d; logic a;} byte_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    int checks = 0;
    int failures = 0;
    int oe_cnt = 0;
    int o;
    byte_t exp_q[$];
    logic [7:0] exp_wr[$];
    logic sn_ps = 1'b1;
    logic sn_pd = 1'b1;
    int sn_nb = 0;
    logic [8:0] sn_sr = '0;
    byte_t sn_e;
    i2c_temp_responder_if bus();
    i2c_temp_responder dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;
    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask
    task automatic wait_q;
        repeat (Q) @(negedge clk);
    endtask
    task automatic i2c_start;
        m_sda = 1'b1; wait_q;
        m_scl = 1'b1; wait_q;
        m_sda = 1'b0; wait_q;
        m_scl = 1'b0; wait_q;
    endtask
    task automatic i2c_stop;
        m_sda = 1'b0; wait_q;
        m_scl = 1'b1; wait_q;
        m_sda = 1'b1; wait_q;
    endtask
    task automatic clock_bit(input logic b);
        m_sda = b; wait_q;
        m_scl = 1'b1; wait_q; wait_q;
        m_scl = 1'b0; wait_q;
    endtask
    task automatic wr(input logic [7:0] d, input logic ack);
        exp_q.push_back({d, ack});
        for (int i = 7; i >= 0; i--) clock_bit(d[i]);
        clock_bit(1'b1);
    endtask
    task automatic rd(input logic [7:0] d, input logic nack);
        exp_q.push_back({d, nack});
        for (int i = 0; i < 8; i++) clock_bit(1'b1);
        clock_bit(nack);
    endtask
    // bus snooper: every 9-clock byte on the wire is compared with the next expected byte/ACK
    initial forever begin
        @(m_scl or bus.sda_in);
        if (m_scl && !sn_ps) begin
            sn_sr = {sn_sr[7:0], bus.sda_in};
            sn_nb++;
            if (sn_nb == 9) begin
                sn_nb = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus byte: got unexpected %0h, want none", sn_sr);
                end else begin
                    sn_e = exp_q.pop_front();
                    check("bus byte", sn_sr[8:1], sn_e.d);
                    check("bus ack", sn_sr[0], sn_e.a);
                end
            end
        end else if (m_scl && sn_ps && bus.sda_in != sn_pd) sn_nb = 0;
        sn_ps = m_scl;
        sn_pd = bus.sda_in;
    end
    // write-strobe monitor
    initial forever begin
        @(negedge clk);
        if (bus.wr_strobe) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_strobe: got strobe with wr_data=%0h, want none", bus.wr_data);
            end else check("wr_data", bus.wr_data, exp_wr.pop_front());
        end
    end
    // counts clocks with SDA driven, for the no-drive check on a foreign address
    always @(negedge clk) if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
    initial begin
        bus.temp_data = 16'h0C80;
        repeat (5) @(negedge clk);
        check("reset sda_oe", bus.sda_oe, 0);
        check("reset reg_ptr", bus.reg_ptr, 0);
        check("reset wr_data", bus.wr_data, 0);
        check("reset wr_strobe", bus.wr_strobe, 0);
        check("reset busy", bus.busy, 0);
        check("reset cfg_reg", bus.cfg_reg, 0);
        reset = 1'b0;
        wait_q;
        i2c_start; wr(8'h90, 0); wr(8'h00, 0);
        i2c_start; wr(8'h91, 0);
        check("busy after match", bus.busy, 1);
        rd(8'h0C, 0); rd(8'h80, 1);
        check("busy after nack", bus.busy, 0);
        i2c_stop;
        check("ptr after temp read", bus.reg_ptr, 8'h02);
        o = oe_cnt;
        i2c_start; wr(8'h92, 1); wr(8'h55, 1); i2c_stop;
        check("sda_oe clocks on foreign addr", oe_cnt - o, 0);
        check("ptr after foreign addr", bus.reg_ptr, 8'h02);
        check("busy after foreign addr", bus.busy, 0);
        i2c_start; wr(8'h90, 0); wr(8'h03, 0);
        exp_wr.push_back(8'h80);
        wr(8'h80, 0); i2c_stop;
        check("cfg_reg", bus.cfg_reg, 8'h80);
        check("wr_data after write", bus.wr_data, 8'h80);
        check("ptr after cfg write", bus.reg_ptr, 8'h04);
        i2c_start; wr(8'h90, 0); wr(8'h03, 0);
        i2c_start; wr(8'h91, 0); rd(8'h80, 1); i2c_stop;
        check("ptr after cfg read", bus.reg_ptr, 8'h04);
        i2c_start; wr(8'h90, 0); wr(8'h0B, 0);
        i2c_start; wr(8'h91, 0); rd(8'hCB, 1); i2c_stop;
        check("ptr after id read", bus.reg_ptr, 8'h0C);
        i2c_start; wr(8'h90, 0); wr(8'hFF, 0);
        i2c_start; wr(8'h91, 0); rd(8'hFF, 0);
        check("ptr wrap", bus.reg_ptr, 8'h00);
        rd(8'h0C, 1);
        check("ptr after wrap read", bus.reg_ptr, 8'h01);
        i2c_stop;
        i2c_start; wr(8'h90, 0); wr(8'h00, 0);
        i2c_start; wr(8'h91, 0); rd(8'h0C, 0);
        bus.temp_data = 16'h1234;
        rd(8'h80, 1); i2c_stop;
        i2c_start; wr(8'h90, 0); wr(8'h00, 0);
        i2c_start; wr(8'h91, 0); rd(8'h12, 0); rd(8'h34, 1); i2c_stop;
        bus.temp_data = 16'h0BB8;
        i2c_start; wr(8'h90, 0); wr(8'h00, 0);
        i2c_start; wr(8'h91, 0);
        m_sda = 1'b1;
        wait_q;
        check("sda_oe driving read msb", bus.sda_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        check("sda_oe after reset", bus.sda_oe, 0);
        check("busy after reset", bus.busy, 0);
        reset = 1'b0;
        wait_q;
        i2c_start; wr(8'h90, 0); wr(8'h01, 0);
        i2c_start; wr(8'h91, 0); rd(8'hB8, 1); i2c_stop;
        check("ptr after post-reset read", bus.reg_ptr, 8'h02);
        check("cfg_reg after reset", bus.cfg_reg, 0);
        repeat (20) @(negedge clk);
        check("bus bytes left", exp_q.size(), 0);
        check("strobes left", exp_wr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
